// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and constants for the serial loader front end
//                and the downstream enabled register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Default word width shared by the loader and the register it feeds.
    localparam int c_default_width = 4;

    // Loader control states; the encoding is fixed so that any unused code
    // can be steered back to IDLE by the next-state logic.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } loader_state_t;

    // Width needed to hold a bit count of 0..n.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/serial_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_loader_if
//  Description : Serial input / parallel output bundle between a bit source,
//                the serial loader and the downstream register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_loader_if
    import seq_pkg::*;
#(
    parameter int N = c_default_width
);

    localparam int CW = count_width(N);

    // Serial side: one qualified bit per clock plus a synchronous abort.
    logic          sin;
    logic          sin_valid;
    logic          clear;

    // Parallel side: completed word, its strobe and progress status.
    logic [N-1:0]  par_out;
    logic          load_en;
    logic          busy;
    logic [CW-1:0] count;

    // Bit source / observer view.
    modport master (
        output sin,
        output sin_valid,
        output clear,
        input  par_out,
        input  load_en,
        input  busy,
        input  count
    );

    // Loader view.
    modport slave (
        input  sin,
        input  sin_valid,
        input  clear,
        output par_out,
        output load_en,
        output busy,
        output count
    );

endinterface : serial_loader_if
`default_nettype wire

// File: rtl/sipo_shift.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shift
//  Description : N-bit serial-in / parallel-out shift register with
//                synchronous clear and shift enable. Bit order is selected
//                by MSB_FIRST; a one-bit instance simply samples sin.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift
    import seq_pkg::*;
#(
    parameter int N         = c_default_width,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,       // asynchronous, active-low
    input  wire logic         clr,
    input  wire logic         shift_en,
    input  wire logic         sin,
    output logic [N-1:0]      q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_next;

    // Next contents of the register after one shift.
    generate
        if (N == 1) begin : g_single
            assign w_next = sin;
        end else if (MSB_FIRST) begin : g_msb_first
            // Oldest bit migrates towards q[N-1].
            assign w_next = {r_q[N-2:0], sin};
        end else begin : g_lsb_first
            // Oldest bit migrates towards q[0].
            assign w_next = {sin, r_q[N-1:1]};
        end
    endgenerate

    // Shift register: clear wins over shift, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : sipo_shift
`default_nettype wire

// File: rtl/serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : serial_loader
//  Description : Serial-in / parallel-out front end for an N-bit enabled
//                register. Assembles N qualified serial bits into a word,
//                presents it on par_out and strobes load_en for one cycle.
//                A bit arriving during the LOAD cycle starts the next word,
//                so back-to-back words lose nothing.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_loader
    import seq_pkg::*;
#(
    parameter int N         = c_default_width,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,        // asynchronous, active-low
    serial_loader_if.slave   bus
);

    localparam int            CW     = count_width(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    loader_state_t r_state;
    loader_state_t w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [N-1:0]  r_par_out;
    logic [N-1:0]  w_shreg;
    logic [N-1:0]  w_shifted;
    logic          w_shift_en;
    logic          w_shreg_clr;
    logic          w_capture;

    // Bit storage for the word under assembly.
    sipo_shift #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_shreg_clr),
        .shift_en (w_shift_en),
        .sin      (bus.sin),
        .q        (w_shreg)
    );

    // The completing bit has not reached the shift register yet when the
    // word is captured, so the capture value is the shift result itself.
    generate
        if (N == 1) begin : g_cap_single
            assign w_shifted = bus.sin;
        end else if (MSB_FIRST) begin : g_cap_msb_first
            assign w_shifted = {w_shreg[N-2:0], bus.sin};
        end else begin : g_cap_lsb_first
            assign w_shifted = {bus.sin, w_shreg[N-1:1]};
        end
    endgenerate

    // State and bit-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state, next count and shift/capture controls. The count is zero
    // in IDLE and LOAD, so "count == N-1" alone identifies the last bit of a
    // word, including the one-bit case where every accepted bit completes.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_en  = 1'b0;
        w_shreg_clr = 1'b0;
        w_capture   = 1'b0;

        if (bus.clear) begin
            // Abort: drop the partial word and this cycle's bit; par_out kept.
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_shreg_clr = 1'b1;
        end else if (bus.sin_valid) begin
            w_shift_en = 1'b1;
            if (r_count == c_LAST) begin
                w_state_nxt = LOAD;
                w_count_nxt = '0;
                w_capture   = 1'b1;
            end else begin
                w_state_nxt = SHIFT;
                w_count_nxt = r_count + CW'(1);
            end
        end else if (r_state != SHIFT) begin
            // SHIFT waits indefinitely for the next bit; LOAD (and any
            // unused encoding) falls back to IDLE.
            w_state_nxt = IDLE;
        end
    end

    // Completed-word register; only updated on the edge entering LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_out <= '0;
        end else if (w_capture) begin
            r_par_out <= w_shifted;
        end
    end

    assign bus.par_out = r_par_out;
    assign bus.load_en = (r_state == LOAD);
    assign bus.busy    = (r_state == SHIFT);
    assign bus.count   = r_count;

endmodule : serial_loader
`default_nettype wire

// File: tb/tb_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_loader
//  Description : Self-checking bench for serial_loader. A scoreboard holds
//                the expected words; a negedge monitor pops and compares on
//                every load_en pulse and checks the downstream register
//                model one cycle later. Extra instances cover LSB-first and
//                one-bit builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_loader;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_loader_if #(.N(4)) bus  ();
    serial_loader_if #(.N(4)) lbus ();
    serial_loader_if #(.N(1)) nbus ();

    serial_loader #(.N(4), .MSB_FIRST(1'b1)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    serial_loader #(.N(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk), .rst (rst), .bus (lbus)
    );
    serial_loader #(.N(1), .MSB_FIRST(1'b1)) u_dut_n1 (
        .clk (clk), .rst (rst), .bus (nbus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pulses   = 0;
    int          busy_cycles = 0;
    int          cyc      = 0;
    int          last_pulse_cyc = 0;
    int          pulse_gap = 0;
    logic [3:0]  sb[$];
    logic [3:0]  r_reg_q;
    logic [3:0]  q_exp;
    bit          q_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Downstream register #(4): captures par_out while load_en is high.
    always @(posedge clk or negedge rst) begin
        if (!rst) r_reg_q <= '0;
        else if (bus.load_en) r_reg_q <= bus.par_out;
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        cyc++;
        if (rst && q_pending) begin
            check("reg_q", 32'(r_reg_q), 32'(q_exp));
            q_pending = 1'b0;
        end
        if (rst && bus.busy) busy_cycles++;
        if (rst && bus.load_en) begin
            pulses++;
            pulse_gap      = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                q_exp = sb.pop_front();
                check("par_out", 32'(bus.par_out), 32'(q_exp));
                q_pending = 1'b1;
            end
        end
    end

    task automatic send_bit(input logic b, input logic v, input logic c);
        @(posedge clk);
        #1;
        bus.sin       = b;
        bus.sin_valid = v;
        bus.clear     = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    // Sends w[3] first, so the word reads the same as the bit sequence.
    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i], 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bits;
        logic       prev;

        rst = 1'b0;
        bus.sin = 1'b0;  bus.sin_valid = 1'b0;  bus.clear = 1'b0;
        lbus.sin = 1'b0; lbus.sin_valid = 1'b0; lbus.clear = 1'b0;
        nbus.sin = 1'b0; nbus.sin_valid = 1'b0; nbus.clear = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_par_out", 32'(bus.par_out), 32'h0);
        check("rst_load_en", 32'(bus.load_en), 32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        check("rst_count",   32'(bus.count),   32'h0);
        rst = 1'b1;

        // 1: continuous 1,0,1,0.
        pulses = 0; busy_cycles = 0;
        sb.push_back(4'hA);
        send_word(4'hA);
        idle(3);
        check("t1_pulses", 32'(pulses), 32'd1);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd3);

        // 2: 0,0,1,1 with two idle cycles after each bit.
        pulses = 0;
        sb.push_back(4'h3);
        bits = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[3-i], 1'b1, 1'b0);
            idle(2);
            if (i < 3) begin
                check("t2_count_hold", 32'(bus.count), 32'(i + 1));
                check("t2_busy_hold",  32'(bus.busy),  32'd1);
            end
        end
        idle(1);
        check("t2_pulses", 32'(pulses), 32'd1);

        // 3: eight continuous bits 0110_1001.
        pulses = 0;
        sb.push_back(4'h6);
        sb.push_back(4'h9);
        send_word(4'h6);
        send_word(4'h9);
        idle(3);
        check("t3_pulses", 32'(pulses), 32'd2);
        check("t3_pulse_gap", 32'(pulse_gap), 32'd4);

        // 4: two bits, clear (with a valid bit that must be dropped), 1,1,0,0.
        pulses = 0;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        idle(1);
        check("t4_clr_count", 32'(bus.count),   32'd0);
        check("t4_clr_busy",  32'(bus.busy),    32'd0);
        check("t4_clr_par",   32'(bus.par_out), 32'h9);
        sb.push_back(4'hC);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("t4_par_held", 32'(bus.par_out), 32'h9);
        check("t4_count",    32'(bus.count),   32'd2);
        send_bit(1'b0, 1'b1, 1'b0);
        idle(3);
        check("t4_pulses", 32'(pulses), 32'd1);

        // 5a: reset mid-word.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        bus.sin_valid = 1'b0;
        check("t5_mid_par",   32'(bus.par_out), 32'h0);
        check("t5_mid_busy",  32'(bus.busy),    32'h0);
        check("t5_mid_count", 32'(bus.count),   32'h0);
        check("t5_mid_load",  32'(bus.load_en), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 5b: reset during the load_en cycle; the pulse must vanish at once.
        send_word(4'hB);
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
        check("t5_load_seen", 32'(bus.load_en), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_ld_load", 32'(bus.load_en), 32'h0);
        check("t5_ld_par",  32'(bus.par_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 5c: normal word after release.
        pulses = 0;
        sb.push_back(4'h5);
        send_word(4'h5);
        idle(3);
        check("t5_pulses", 32'(pulses), 32'd1);

        // 6a: LSB-first build, bits 1,0,0,0.
        bits = 4'b1000;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk);
            #1;
            lbus.sin       = bits[i];
            lbus.sin_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        lbus.sin_valid = 1'b0;
        @(negedge clk);
        check("t6_lsb_load", 32'(lbus.load_en), 32'd1);
        check("t6_lsb_par",  32'(lbus.par_out), 32'h1);

        // 6b: one-bit build with toggling sin; a pulse per valid cycle.
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            nbus.sin       = i[0];
            nbus.sin_valid = 1'b1;
            if (i > 0) begin
                @(negedge clk);
                check("t6_n1_load", 32'(nbus.load_en), 32'd1);
                check("t6_n1_par",  32'(nbus.par_out), 32'(prev));
                check("t6_n1_busy", 32'(nbus.busy),    32'd0);
            end
            prev = i[0];
        end
        @(posedge clk);
        #1;
        nbus.sin_valid = 1'b0;
        @(negedge clk);
        check("t6_n1_last", 32'(nbus.par_out), 32'(prev));
        @(negedge clk);
        check("t6_n1_idle", 32'(nbus.load_en), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_loader
`default_nettype wire
